// File: rtl/woz_pkg.sv
// rtl/woz_pkg.sv - shared constants, state type and helpers for the WOZ bit streamer
//
// Purpose: common definitions imported by woz_bit_stream and woz_lfsr16.
// Contents: track size limits, address/position widths, streamer state enum,
//           weak-bit LFSR seed and the bit_count validity check.
package woz_pkg;

  localparam int WOZ_MAX_BITS = 131072;
  localparam int WOZ_POS_W    = 17;
  localparam int WOZ_ADDR_W   = 14;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } woz_bs_state_t;

  // A track is streamable only if it has at least one bit and fits the buffer.
  function automatic logic woz_count_ok(input logic [31:0] bit_count);
    return (bit_count != 32'd0) && (bit_count <= 32'(WOZ_MAX_BITS));
  endfunction

endpackage

// File: rtl/woz_lfsr16.sv
// rtl/woz_lfsr16.sv - 16-bit Fibonacci LFSR noise source for weak-bit emulation
//
// Purpose: pseudo-random bit source, polynomial x^16+x^14+x^13+x^11+1,
//          seeded with LFSR_SEED on reset. Used only when
//          WOZ_BITSTREAM_FAKEBITS_EN is defined.
// Ports:
//   i_clk      in  1  clock
//   i_reset_n  in  1  synchronous active-low reset (reloads the seed)
//   i_en       in  1  advance the register by one step
//   o_bit      out 1  current output bit (LSB of the register)
module woz_lfsr16
  import woz_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Taps x^16, x^14, x^13, x^11 map to register bits 0, 2, 3, 5 in a
  // right-shifting register whose output is bit 0.
  assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign o_bit = r_lfsr[0];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

endmodule

// File: rtl/woz_bit_stream.sv
// rtl/woz_bit_stream.sv - serialises WOZ track bits into timed flux bit cells
//
// Purpose: reads track bytes from the track buffer, emits one bit per cell
//          (MSB first), wraps at bit_count, pulses index on bit 0 and keeps the
//          rotational position across track reloads.
// Optional feature: WOZ_BITSTREAM_FAKEBITS_EN enables MC3470 weak-bit
//          emulation (runs of more than three zeros read back as noise).
// Ports:
//   i_clk            in  1   system clock
//   i_reset_n        in  1   synchronous active-low reset
//   i_ready          in  1   track buffer holds valid data
//   i_bit_count      in  32  bits in current track
//   o_bit_byte_addr  out 14  byte address into track buffer
//   i_bit_byte_data  in  8   byte at o_bit_byte_addr (one cycle latency)
//   i_motor_on       in  1   spindle running
//   i_is_35          in  1   selects CELL_CLKS_35 vs CELL_CLKS_525
//   o_active         out 1   streaming; track buffer must not reload
//   o_flux_strobe    out 1   one-cycle pulse at the end of each bit cell
//   o_flux_bit       out 1   bit value, valid with o_flux_strobe
//   o_index          out 1   pulse coincident with the strobe of bit 0
//   o_bit_pos        out 17  position of the next bit to emit
module woz_bit_stream
  import woz_pkg::*;
#(
  parameter int CELL_CLKS_525 = 56,
  parameter int CELL_CLKS_35  = 28
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ready,
  input  logic [31:0]           i_bit_count,
  output logic [WOZ_ADDR_W-1:0] o_bit_byte_addr,
  input  logic [7:0]            i_bit_byte_data,
  input  logic                  i_motor_on,
  input  logic                  i_is_35,
  output logic                  o_active,
  output logic                  o_flux_strobe,
  output logic                  o_flux_bit,
  output logic                  o_index,
  output logic [WOZ_POS_W-1:0]  o_bit_pos
);

  localparam int CNT_W = 16;

  woz_bs_state_t          r_state;
  woz_bs_state_t          w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [WOZ_POS_W-1:0]   r_bit_pos;
  logic [WOZ_ADDR_W-1:0]  r_addr;
  logic [7:0]             r_cur_byte;
  logic                   r_strobe;
  logic                   r_flux_bit;
  logic                   r_index;

  logic                   w_count_ok;
  logic                   w_go;
  logic                   w_cell_end;
  logic                   w_clamp;
  logic [CNT_W-1:0]       w_reload;
  logic                   w_src_bit;
  logic                   w_out_bit;
  logic [WOZ_POS_W-1:0]   w_pos_inc;
  logic [WOZ_POS_W-1:0]   w_pos_next;

  assign w_count_ok = woz_count_ok(i_bit_count);
  assign w_go       = i_motor_on & i_ready & w_count_ok;

  // Reload value is chosen at reload time, so an is_35 change only affects
  // the cell that starts after the next reload.
  assign w_reload   = i_is_35 ? CNT_W'(CELL_CLKS_35 - 1) : CNT_W'(CELL_CLKS_525 - 1);

  // Losing ready/motor/count in the final cycle of a cell suppresses its strobe.
  assign w_cell_end = (r_state == RUN) && w_go && (r_cnt == '0);

  // A shorter track after a reload may leave the head beyond its end.
  assign w_clamp    = ({{(32-WOZ_POS_W){1'b0}}, r_bit_pos} >= i_bit_count);

  assign w_src_bit  = r_cur_byte[3'd7 - r_bit_pos[2:0]];

  // 17-bit compare: bit_count == 131072 has bit_count[16:0] == 0, and the
  // natural overflow of the increment lands on 0 at the same point.
  assign w_pos_inc  = r_bit_pos + 1'b1;
  assign w_pos_next = (w_pos_inc == i_bit_count[WOZ_POS_W-1:0]) ? '0 : w_pos_inc;

`ifdef WOZ_BITSTREAM_FAKEBITS_EN
  logic [1:0] r_zrun;
  logic       w_lfsr_bit;

  woz_lfsr16 u_lfsr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (w_cell_end),
    .o_bit     (w_lfsr_bit)
  );

  // Past three consecutive zeros the read amplifier has lost its AGC
  // reference, so the emitted bit becomes noise.
  assign w_out_bit = (!w_src_bit && (r_zrun == 2'd3)) ? w_lfsr_bit : w_src_bit;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_zrun <= 2'd0;
    end else if (w_cell_end) begin
      if (w_src_bit) begin
        r_zrun <= 2'd0;
      end else if (r_zrun != 2'd3) begin
        r_zrun <= r_zrun + 2'd1;
      end
    end
  end
`else
  assign w_out_bit = w_src_bit;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_next = PRIME;
      PRIME:   w_state_next = RUN;
      RUN:     if (!w_go) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_pos  <= '0;
      r_addr     <= '0;
      r_cur_byte <= '0;
      r_strobe   <= 1'b0;
      r_flux_bit <= 1'b0;
      r_index    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_byte <= i_bit_byte_data;
      r_addr     <= r_bit_pos[WOZ_POS_W-1:3];
      r_strobe   <= 1'b0;
      r_flux_bit <= 1'b0;
      r_index    <= 1'b0;
      case (r_state)
        PRIME: begin
          if (w_clamp) r_bit_pos <= '0;
          r_cnt <= w_reload;
        end
        RUN: begin
          if (w_cell_end) begin
            r_strobe   <= 1'b1;
            r_flux_bit <= w_out_bit;
            r_index    <= (r_bit_pos == '0);
            r_bit_pos  <= w_pos_next;
            r_cnt      <= w_reload;
          end else if (w_go) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_active        = (r_state != IDLE);
  assign o_flux_strobe   = r_strobe;
  assign o_flux_bit      = r_flux_bit;
  assign o_index         = r_index;
  assign o_bit_pos       = r_bit_pos;
  assign o_bit_byte_addr = r_addr;

endmodule
